// File: rtl/camera_pkg.sv
// Shared types and constants for the camera capture / YCbCr / 8x8 block front end.
package camera_pkg;

    localparam int unsigned BLOCK  = 8;
    localparam int unsigned NUM_CH = 3;

    // Channel index on the block output port.
    localparam int unsigned CH_Y  = 0;
    localparam int unsigned CH_CB = 1;
    localparam int unsigned CH_CR = 2;

    localparam int unsigned SUM_W = 18;

    // Colour conversion coefficients (8-bit fixed point).
    localparam logic signed [SUM_W-1:0] COEF_YR  =  18'sd77;
    localparam logic signed [SUM_W-1:0] COEF_YG  =  18'sd150;
    localparam logic signed [SUM_W-1:0] COEF_YB  =  18'sd29;
    localparam logic signed [SUM_W-1:0] COEF_CBR = -18'sd43;
    localparam logic signed [SUM_W-1:0] COEF_CBG = -18'sd85;
    localparam logic signed [SUM_W-1:0] COEF_CBB =  18'sd128;
    localparam logic signed [SUM_W-1:0] COEF_CRR =  18'sd128;
    localparam logic signed [SUM_W-1:0] COEF_CRG = -18'sd107;
    localparam logic signed [SUM_W-1:0] COEF_CRB = -18'sd21;
    localparam logic signed [SUM_W-1:0] CHROMA_OFFSET = 18'sd32768;

    // One block row beat for one channel; row[0] is the leftmost sample.
    typedef struct packed {
        logic                  valid;
        logic                  sob;
        logic                  eob;
        logic [BLOCK-1:0][7:0] row;
    } dctPort_t;

    typedef enum logic {
        IDLE,
        READ
    } rd_state_e;

endpackage

// File: rtl/camera_dct_top_rgb2ycbcr.sv
// Two-stage RGB888 -> YCbCr converter with clamp; LEVEL_SHIFT_EN selects signed (x-128) output.
module rgb2ycbcr
    import camera_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    output logic       out_valid,
    output logic [7:0] y_out,
    output logic [7:0] cb_out,
    output logic [7:0] cr_out
);

    logic signed [SUM_W-1:0] r_s, g_s, b_s;
    logic signed [SUM_W-1:0] y_sum_d, cb_sum_d, cr_sum_d;
    logic signed [SUM_W-1:0] y_sum_q, cb_sum_q, cr_sum_q;
    logic                    v1_d, v1_q, v2_d, v2_q;
    logic [7:0]              y_d, cb_d, cr_d, y_q, cb_q, cr_q;

    assign r_s = {10'd0, r_in};
    assign g_s = {10'd0, g_in};
    assign b_s = {10'd0, b_in};

    // Drop the fraction, clamp to a byte, optionally recentre around zero.
    function automatic logic [7:0] finish_sample(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] q;
        logic [7:0]              v;
        q = s >>> 8;
        if (q < 18'sd0) begin
            v = 8'd0;
        end else if (q > 18'sd255) begin
            v = 8'd255;
        end else begin
            v = q[7:0];
        end
`ifdef LEVEL_SHIFT_EN
        // Subtracting 128 from an 8-bit value is an MSB flip.
        v = v ^ 8'h80;
`endif
        return v;
    endfunction

    // Stage 1 multiply-add, stage 2 shift/clamp.
    always_comb begin
        y_sum_d  = COEF_YR  * r_s + COEF_YG  * g_s + COEF_YB  * b_s;
        cb_sum_d = COEF_CBR * r_s + COEF_CBG * g_s + COEF_CBB * b_s + CHROMA_OFFSET;
        cr_sum_d = COEF_CRR * r_s + COEF_CRG * g_s + COEF_CRB * b_s + CHROMA_OFFSET;
        v1_d     = in_valid;
        v2_d     = v1_q;
        y_d      = finish_sample(y_sum_q);
        cb_d     = finish_sample(cb_sum_q);
        cr_d     = finish_sample(cr_sum_q);
    end

    // Pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_sum_q  <= '0;
            cb_sum_q <= '0;
            cr_sum_q <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            y_q      <= '0;
            cb_q     <= '0;
            cr_q     <= '0;
        end else begin
            y_sum_q  <= y_sum_d;
            cb_sum_q <= cb_sum_d;
            cr_sum_q <= cr_sum_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            y_q      <= y_d;
            cb_q     <= cb_d;
            cr_q     <= cr_d;
        end
    end

    assign out_valid = v2_q;
    assign y_out     = y_q;
    assign cb_out    = cb_q;
    assign cr_out    = cr_q;

endmodule

// File: rtl/camera_dct_top.sv
// DVP RGB888 capture -> YCbCr -> ping-pong 8-line strips -> 8x8 block rows on Y/Cb/Cr ports.
// Optional build macro: LEVEL_SHIFT_EN (signed, level-shifted samples).
// Note: rst_n is an active-high asynchronous reset.
module camera_dct_top
    import camera_pkg::*;
#(
    parameter int unsigned WIDTH  = 24,
    parameter int unsigned HEIGHT = 16
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vsync,
    input  logic                     href,
    input  logic [7:0]               data,
    output dctPort_t [NUM_CH-1:0]    out
);

    localparam int unsigned COL_W     = $clog2(WIDTH + 1);
    localparam int unsigned COL_IDX_W = $clog2(WIDTH);
    localparam int unsigned LINE_W    = $clog2(HEIGHT + 1);
    localparam int unsigned ROW_W     = $clog2(BLOCK);
    localparam int unsigned NBLK      = WIDTH / BLOCK;
    localparam int unsigned BLK_W     = (NBLK > 1) ? $clog2(NBLK) : 1;

    // Capture state.
    logic [1:0]        byte_d, byte_q;
    logic [COL_W-1:0]  col_d, col_q;
    logic [LINE_W-1:0] line_d, line_q;
    logic              wbank_d, wbank_q;
    logic              href_q;
    logic [7:0]        r_d, r_q, g_d, g_q;
    logic              pix_valid_c, strip_done_c;

    // Write-address pipeline aligned with the converter latency.
    logic                 mv1_d, mv1_q;
    logic                 mb1_d, mb1_q, mb2_d, mb2_q;
    logic [ROW_W-1:0]     ml1_d, ml1_q, ml2_d, ml2_q;
    logic [COL_IDX_W-1:0] mc1_d, mc1_q, mc2_d, mc2_q;

    logic       cvt_valid;
    logic [7:0] cvt_y, cvt_cb, cvt_cr;

    // Strip storage and readout.
    logic [7:0]             mem_q [2][NUM_CH][BLOCK][WIDTH];
    logic [1:0]             full_d, full_q;
    rd_state_e              state_d, state_q;
    logic                   rbank_d, rbank_q;
    logic [BLK_W-1:0]       blk_d, blk_q;
    logic [ROW_W-1:0]       row_d, row_q;
    dctPort_t [NUM_CH-1:0]  out_d, out_q;

    rgb2ycbcr u_cvt (
        .clk       (clk),
        .rst       (rst_n),
        .in_valid  (pix_valid_c),
        .r_in      (r_q),
        .g_in      (g_q),
        .b_in      (data),
        .out_valid (cvt_valid),
        .y_out     (cvt_y),
        .cb_out    (cvt_cb),
        .cr_out    (cvt_cr)
    );

    // Byte/column/line counting, pixel completion and strip completion.
    always_comb begin
        byte_d       = byte_q;
        col_d        = col_q;
        line_d       = line_q;
        wbank_d      = wbank_q;
        r_d          = r_q;
        g_d          = g_q;
        pix_valid_c  = 1'b0;
        strip_done_c = 1'b0;
        if (vsync) begin
            byte_d  = 2'd0;
            col_d   = '0;
            line_d  = '0;
            wbank_d = 1'b0;
        end else if (href) begin
            case (byte_q)
                2'd0: begin
                    r_d    = data;
                    byte_d = 2'd1;
                end
                2'd1: begin
                    g_d    = data;
                    byte_d = 2'd2;
                end
                default: begin
                    byte_d = 2'd0;
                    if (col_q < COL_W'(WIDTH)) begin
                        col_d       = col_q + COL_W'(1);
                        pix_valid_c = (line_q < LINE_W'(HEIGHT));
                    end
                end
            endcase
        end else begin
            byte_d = 2'd0;
            if (href_q && (col_q != '0)) begin
                col_d = '0;
                if (line_q < LINE_W'(HEIGHT)) begin
                    line_d = line_q + LINE_W'(1);
                    if (line_q[ROW_W-1:0] == ROW_W'(BLOCK - 1)) begin
                        strip_done_c = 1'b1;
                        wbank_d      = ~wbank_q;
                    end
                end
            end
        end
    end

    // Tag each pixel with its bank/line/column until the converter result arrives.
    always_comb begin
        mv1_d = pix_valid_c;
        mb1_d = wbank_q;
        ml1_d = line_q[ROW_W-1:0];
        mc1_d = COL_IDX_W'(col_q);
        mb2_d = mb1_q;
        ml2_d = ml1_q;
        mc2_d = mc1_q;
    end

    // Readout FSM: walk blocks left to right, rows 0..7 per block, one beat per clock.
    always_comb begin
        state_d = state_q;
        rbank_d = rbank_q;
        blk_d   = blk_q;
        row_d   = row_q;
        full_d  = full_q;
        out_d   = '0;
        case (state_q)
            IDLE: begin
                if (full_q[0] || full_q[1]) begin
                    state_d = READ;
                    rbank_d = ~full_q[0];
                    blk_d   = '0;
                    row_d   = '0;
                end
            end
            READ: begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    out_d[c].valid = 1'b1;
                    out_d[c].sob   = (row_q == '0);
                    out_d[c].eob   = (row_q == ROW_W'(BLOCK - 1));
                    for (int unsigned i = 0; i < BLOCK; i++) begin
                        out_d[c].row[i] =
                            mem_q[rbank_q][c][row_q][COL_IDX_W'(32'(blk_q) * BLOCK + i)];
                    end
                end
                if (row_q == ROW_W'(BLOCK - 1)) begin
                    row_d = '0;
                    if (blk_q == BLK_W'(NBLK - 1)) begin
                        blk_d          = '0;
                        full_d[rbank_q] = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        blk_d = blk_q + BLK_W'(1);
                    end
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (strip_done_c) begin
            full_d[wbank_q] = 1'b1;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            byte_d_reset: begin
                byte_q  <= '0;
                col_q   <= '0;
                line_q  <= '0;
                wbank_q <= 1'b0;
                href_q  <= 1'b0;
                r_q     <= '0;
                g_q     <= '0;
                mv1_q   <= 1'b0;
                mb1_q   <= 1'b0;
                ml1_q   <= '0;
                mc1_q   <= '0;
                mb2_q   <= 1'b0;
                ml2_q   <= '0;
                mc2_q   <= '0;
                full_q  <= '0;
                state_q <= IDLE;
                rbank_q <= 1'b0;
                blk_q   <= '0;
                row_q   <= '0;
                out_q   <= '0;
            end
        end else begin
            byte_q  <= byte_d;
            col_q   <= col_d;
            line_q  <= line_d;
            wbank_q <= wbank_d;
            href_q  <= href;
            r_q     <= r_d;
            g_q     <= g_d;
            mv1_q   <= mv1_d;
            mb1_q   <= mb1_d;
            ml1_q   <= ml1_d;
            mc1_q   <= mc1_d;
            mb2_q   <= mb2_d;
            ml2_q   <= ml2_d;
            mc2_q   <= mc2_d;
            full_q  <= full_d;
            state_q <= state_d;
            rbank_q <= rbank_d;
            blk_q   <= blk_d;
            row_q   <= row_d;
            out_q   <= out_d;
        end
    end

    // Strip buffer write port; contents survive reset and short lines.
    always_ff @(posedge clk) begin
        if (cvt_valid) begin
            mem_q[mb2_q][CH_Y][ml2_q][mc2_q]  <= cvt_y;
            mem_q[mb2_q][CH_CB][ml2_q][mc2_q] <= cvt_cb;
            mem_q[mb2_q][CH_CR][ml2_q][mc2_q] <= cvt_cr;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_camera_dct_top.sv
// Randomised bench for camera_dct_top with a line-level image model and an expected-beat queue.
module tb_camera_dct_top;
    import camera_pkg::*;

    localparam int W  = 24;
    localparam int H  = 16;
    localparam int NB = W / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            vsync;
    logic            href;
    logic [7:0]      data;
    dctPort_t [2:0]  out;

    camera_dct_top #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vsync (vsync),
        .href  (href),
        .data  (data),
        .out   (out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][7:0][7:0] s;
        logic                 sob;
        logic                 eob;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    beat_cnt = 0;
    int    sob_cnt = 0;
    beat_t exp_q[$];
    beat_t log_q[$];

    // Model image store: [bank][line in strip][column][channel].
    logic [7:0] mm [2][8][W][3];
    int         m_line = 0;
    int         m_wb = 0;

    function automatic logic [7:0] conv(input int r, input int g, input int b, input int ch);
        int v;
        case (ch)
            0:       v = (77 * r + 150 * g + 29 * b) >>> 8;
            1:       v = (-43 * r - 85 * g + 128 * b + 32768) >>> 8;
            default: v = (128 * r - 107 * g - 21 * b + 32768) >>> 8;
        endcase
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
`ifdef LEVEL_SHIFT_EN
        return 8'(v - 128);
`else
        return 8'(v);
`endif
    endfunction

    function automatic logic [7:0] lit(input int v);
`ifdef LEVEL_SHIFT_EN
        return 8'(v - 128);
`else
        return 8'(v);
`endif
    endfunction

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Compare process: every output cycle against the expected-beat queue.
    int blk_open = 0;
    always @(negedge clk) begin
        beat_t e, g;
        if (rst_n) begin
            blk_open = 0;
            checks++;
            if (out !== '0) begin
                errors++;
                $display("FAIL reset_out got %h exp 0", out);
            end
        end else if (out[0].valid || out[1].valid || out[2].valid) begin
            for (int c = 0; c < 3; c++) g.s[c] = out[c].row;
            g.sob = out[0].sob;
            g.eob = out[0].eob;
            log_q.push_back(g);
            beat_cnt++;
            if (g.sob) sob_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_beat got %h exp none", g);
            end else begin
                e = exp_q.pop_front();
                if (g !== e || !(out[0].valid && out[1].valid && out[2].valid) ||
                    out[1].sob !== e.sob || out[2].sob !== e.sob ||
                    out[1].eob !== e.eob || out[2].eob !== e.eob) begin
                    errors++;
                    $display("FAIL beat%0d got %h v=%b%b%b exp %h", beat_cnt, g,
                             out[0].valid, out[1].valid, out[2].valid, e);
                end
                blk_open = e.eob ? 0 : 1;
            end
        end else if (blk_open != 0) begin
            checks++;
            errors++;
            blk_open = 0;
            $display("FAIL block_gap got valid 0 exp valid 1");
        end
    end

    task automatic push_strip(input int bank);
        beat_t e;
        for (int b = 0; b < NB; b++) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 3; c++)
                    for (int i = 0; i < 8; i++)
                        e.s[c][i] = mm[bank][r][8 * b + i][c];
                e.sob = (r == 0);
                e.eob = (r == 7);
                exp_q.push_back(e);
            end
        end
    endtask

    // mode 0: R,G,B = 1,2,3; mode 1: R = column; mode 2: random.
    task automatic send_line(input int mode, input int npix, input int extra);
        int pr[W + 4], pg[W + 4], pb[W + 4];
        int nbytes;
        for (int x = 0; x < W + 4; x++) begin
            case (mode)
                0:       begin pr[x] = 1; pg[x] = 2; pb[x] = 3; end
                1:       begin pr[x] = x; pg[x] = 0; pb[x] = 0; end
                default: begin
                    pr[x] = int'($urandom_range(0, 255));
                    pg[x] = int'($urandom_range(0, 255));
                    pb[x] = int'($urandom_range(0, 255));
                end
            endcase
        end
        if (npix > 0 && m_line < H) begin
            for (int x = 0; x < npix && x < W; x++)
                for (int c = 0; c < 3; c++)
                    mm[m_wb][m_line % 8][x][c] = conv(pr[x], pg[x], pb[x], c);
            m_line++;
            if (m_line % 8 == 0) begin
                push_strip(m_wb);
                m_wb ^= 1;
            end
        end
        nbytes = 3 * npix + extra;
        for (int k = 0; k < nbytes; k++) begin
            @(posedge clk); #1;
            href = 1'b1;
            if (k / 3 >= npix)  data = 8'($urandom);
            else if (k % 3 == 0) data = 8'(pr[k / 3]);
            else if (k % 3 == 1) data = 8'(pg[k / 3]);
            else                 data = 8'(pb[k / 3]);
        end
        @(posedge clk); #1;
        href = 1'b0;
        data = 8'($urandom);
        repeat (4) @(posedge clk);
    endtask

    task automatic frame_start();
        @(posedge clk); #1;
        vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1 vsync = 1'b0;
        m_line = 0;
        m_wb = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic drain();
        repeat (80) @(posedge clk);
        check_val("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    int b0;

    initial begin
        rst_n = 1'b1;
        vsync = 1'b0;
        href  = 1'b0;
        data  = 8'd0;

        // Pin the model against hand-worked conversions.
        check_val("model_y_123",  64'(conv(1, 2, 3, 0)), 64'(lit(1)));
        check_val("model_cb_123", 64'(conv(1, 2, 3, 1)), 64'(lit(128)));
        check_val("model_cr_123", 64'(conv(1, 2, 3, 2)), 64'(lit(127)));
        check_val("model_y_white", 64'(conv(255, 255, 255, 0)), 64'(lit(255)));
        check_val("model_cr_red",  64'(conv(255, 0, 0, 2)), 64'(lit(255)));

        // Stimulus toggling while reset is held; outputs must stay cleared.
        repeat (20) begin
            @(posedge clk); #1;
            href  = 1'($urandom);
            vsync = 1'($urandom);
            data  = 8'($urandom);
        end
        href = 1'b0;
        vsync = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (20) @(posedge clk);

        // Constant frame.
        frame_start();
        b0 = beat_cnt;
        log_q.delete();
        for (int l = 0; l < H; l++) send_line(0, W, 0);
        drain();
        check_val("const_beats", 64'(beat_cnt - b0), 64'd48);
        check_val("const_sob", 64'(sob_cnt), 64'd6);
        if (log_q.size() == 48) begin
            check_val("const_y_row",  log_q[0].s[0], {8{lit(1)}});
            check_val("const_cb_row", log_q[47].s[1], {8{lit(128)}});
            check_val("const_cr_row", log_q[23].s[2], {8{lit(127)}});
            check_val("const_sob_eob_b7", {62'd0, log_q[7].sob, log_q[7].eob}, 64'd1);
        end else begin
            checks++;
            errors++;
            $display("FAIL const_log_size got %0d exp 48", log_q.size());
        end

        // Gradient frame: R = column index.
        frame_start();
        b0 = beat_cnt;
        log_q.delete();
        for (int l = 0; l < H; l++) send_line(1, W, 0);
        drain();
        check_val("grad_beats", 64'(beat_cnt - b0), 64'd48);
        if (log_q.size() > 16)
            check_val("grad_blk2_y", log_q[16].s[0],
                      {lit(6), lit(6), lit(6), lit(6), lit(5), lit(5), lit(5), lit(4)});
        else begin
            checks++;
            errors++;
            $display("FAIL grad_log_size got %0d exp 48", log_q.size());
        end

        // Short first line, then full lines.
        frame_start();
        b0 = beat_cnt;
        send_line(2, 10, 0);
        for (int l = 1; l < H; l++) send_line(2, W, 0);
        drain();
        check_val("short_beats", 64'(beat_cnt - b0), 64'd48);

        // Lines ending with a stray partial-pixel byte.
        frame_start();
        b0 = beat_cnt;
        for (int l = 0; l < H; l++) send_line(2, W, 1);
        drain();
        check_val("extra_byte_beats", 64'(beat_cnt - b0), 64'd48);

        // vsync in the middle of a strip.
        frame_start();
        for (int l = 0; l < 3; l++) send_line(2, W, 0);
        frame_start();
        b0 = beat_cnt;
        for (int l = 0; l < 8; l++) send_line(2, W, 0);
        drain();
        check_val("vsync_mid_beats", 64'(beat_cnt - b0), 64'd24);

        // Reset part-way through a frame, then a frame with long/extra lines.
        frame_start();
        for (int l = 0; l < 5; l++) send_line(2, W, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.delete();
        m_line = 0;
        m_wb = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        frame_start();
        b0 = beat_cnt;
        for (int l = 0; l < H + 2; l++)
            send_line(2, W + int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        drain();
        check_val("random_beats", 64'(beat_cnt - b0), 64'd48);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
